// File: rtl/key_highlight_controller.sv
// Key highlight controller: accepts key presses from the keyboard or the
// playback sequencer and shows the key on screen for HOLD_FRAMES frames.
// The display only changes on frame_start, so a frame is never drawn with
// two different highlights.
module key_highlight_controller #(
    parameter int HOLD_FRAMES = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  logic [1:0] function_mode,
    input  logic       kb_valid,
    input  logic [3:0] kb_key,
    input  logic       seq_valid,
    input  logic [3:0] seq_key,
    output logic       seq_ready,
    output logic [3:0] key_highlight,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SHOW    = 2'd2
    } state_e;

    localparam logic [5:0] HOLD_M1 = 6'(HOLD_FRAMES - 1);

    state_e     state_q, state_d;
    logic [3:0] key_highlight_q, key_highlight_d;
    logic [3:0] pending_key_q, pending_key_d;
    logic       pending_valid_q, pending_valid_d;
    logic [5:0] frame_cnt_q, frame_cnt_d;

    logic       mode_kbd;
    logic       req_acc;
    logic [3:0] req_key;
    logic       req_ok;
    logic       apply_pending;

    // Request arbitration: keyboard always wins over the sequencer; menus block both.
    always_comb begin
        mode_kbd  = (function_mode == 2'd0);
        seq_ready = mode_kbd & ~kb_valid & ~Reset;
        req_acc   = mode_kbd & (kb_valid | (seq_valid & seq_ready));
        req_key   = kb_valid ? kb_key : seq_key;
        // Out-of-range keys still complete the handshake but are discarded.
        req_ok    = req_acc & (req_key >= 4'd1) & (req_key <= 4'd12);
    end

    // Next-state logic: frame boundary bookkeeping first, then a new request
    // (so a coincident request becomes pending for the following frame).
    always_comb begin
        state_d         = state_q;
        key_highlight_d = key_highlight_q;
        pending_key_d   = pending_key_q;
        pending_valid_d = pending_valid_q;
        frame_cnt_d     = frame_cnt_q;
        apply_pending   = (state_q == PENDING) || ((state_q == SHOW) && pending_valid_q);

        if (!mode_kbd) begin
            state_d         = IDLE;
            key_highlight_d = 4'd0;
            pending_valid_d = 1'b0;
            frame_cnt_d     = 6'd0;
        end else begin
            if (frame_start) begin
                if (apply_pending) begin
                    key_highlight_d = pending_key_q;
                    frame_cnt_d     = HOLD_M1;
                    pending_valid_d = 1'b0;
                    state_d         = SHOW;
                end else if (state_q == SHOW) begin
                    if (frame_cnt_q != 6'd0) begin
                        frame_cnt_d = frame_cnt_q - 6'd1;
                    end else begin
                        key_highlight_d = 4'd0;
                        state_d         = IDLE;
                    end
                end
            end
            if (req_ok) begin
                pending_key_d   = req_key;
                pending_valid_d = 1'b1;
                if (state_d == IDLE) begin
                    state_d = PENDING;
                end
            end
        end
    end

    // State registers; reset overrides everything including frame_start.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q         <= IDLE;
            key_highlight_q <= 4'd0;
            pending_key_q   <= 4'd0;
            pending_valid_q <= 1'b0;
            frame_cnt_q     <= 6'd0;
        end else begin
            state_q         <= state_d;
            key_highlight_q <= key_highlight_d;
            pending_key_q   <= pending_key_d;
            pending_valid_q <= pending_valid_d;
            frame_cnt_q     <= frame_cnt_d;
        end
    end

    assign key_highlight = key_highlight_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_key_highlight_controller.sv
// Directed bench for key_highlight_controller with HOLD_FRAMES = 8.
module tb_key_highlight_controller;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_start = 1'b0;
    logic [1:0] function_mode = 2'd0;
    logic       kb_valid = 1'b0;
    logic [3:0] kb_key = 4'd0;
    logic       seq_valid = 1'b0;
    logic [3:0] seq_key = 4'd0;
    logic       seq_ready;
    logic [3:0] key_highlight;
    logic       busy;

    int n_vec = 0;
    int n_bad = 0;

    key_highlight_controller #(.HOLD_FRAMES(8)) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
        .function_mode(function_mode), .kb_valid(kb_valid), .kb_key(kb_key),
        .seq_valid(seq_valid), .seq_key(seq_key), .seq_ready(seq_ready),
        .key_highlight(key_highlight), .busy(busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic kb(input logic [3:0] k);
        kb_valid = 1'b1;
        kb_key   = k;
        tick();
        kb_valid = 1'b0;
    endtask

    initial begin
        // reset
        tick();
        #1 chk("rst_seq_ready", seq_ready, 0);
        tick();
        chk("rst_kh", key_highlight, 0);
        chk("rst_busy", busy, 0);
        Reset = 1'b0;
        #1 chk("post_rst_seq_ready", seq_ready, 1);
        tick();

        // key 5 mid-frame, held 8 pulses then cleared
        kb(4'd5);
        chk("k5_busy", busy, 1);
        chk("k5_kh_pend", key_highlight, 0);
        tick(); tick();
        chk("k5_kh_midframe", key_highlight, 0);
        for (int i = 1; i <= 8; i++) begin
            pulse();
            chk($sformatf("k5_hold%0d", i), key_highlight, 5);
        end
        pulse();
        chk("k5_expired", key_highlight, 0);
        chk("k5_idle", busy, 0);

        // kb and seq in the same cycle; seq wins the next cycle
        kb_valid = 1'b1; kb_key = 4'd3;
        seq_valid = 1'b1; seq_key = 4'd7;
        #1 chk("prio_seq_ready0", seq_ready, 0);
        tick();
        kb_valid = 1'b0;
        #1 chk("prio_seq_ready1", seq_ready, 1);
        tick();
        seq_valid = 1'b0;
        chk("prio_busy", busy, 1);
        pulse();
        chk("prio_kh7", key_highlight, 7);
        for (int i = 0; i < 8; i++) pulse();
        chk("prio_drain_kh", key_highlight, 0);
        chk("prio_drain_busy", busy, 0);

        // restart hold mid-show
        kb(4'd4);
        pulse(); pulse(); pulse();
        chk("rst_hold_kh4", key_highlight, 4);
        kb(4'd9);
        chk("rst_hold_still4", key_highlight, 4);
        pulse();
        chk("rst_hold_kh9", key_highlight, 9);
        for (int i = 1; i <= 7; i++) begin
            pulse();
            chk($sformatf("rst_hold9_%0d", i), key_highlight, 9);
        end
        pulse();
        chk("rst_hold_done", key_highlight, 0);

        // out-of-range keys dropped
        kb(4'd0);
        chk("key0_busy", busy, 0);
        kb(4'd14);
        chk("key14_busy", busy, 0);
        pulse();
        chk("badkey_kh", key_highlight, 0);

        // coincident frame_start and request
        kb(4'd1);
        frame_start = 1'b1; kb_valid = 1'b1; kb_key = 4'd2;
        tick();
        frame_start = 1'b0; kb_valid = 1'b0;
        chk("coinc_kh1", key_highlight, 1);
        pulse();
        chk("coinc_kh2", key_highlight, 2);
        for (int i = 0; i < 8; i++) pulse();
        chk("coinc_drain", key_highlight, 0);

        // menu mode suppresses, then sequencer resumes
        kb(4'd6);
        pulse();
        chk("menu_kh6", key_highlight, 6);
        function_mode = 2'd1;
        #1 chk("menu_seq_ready", seq_ready, 0);
        tick();
        chk("menu_kh0", key_highlight, 0);
        chk("menu_busy", busy, 0);
        kb(4'd8);
        chk("menu_kb_ignored", busy, 0);
        function_mode = 2'd0;
        seq_valid = 1'b1; seq_key = 4'd11;
        #1 chk("menu_back_ready", seq_ready, 1);
        tick();
        seq_valid = 1'b0;
        chk("menu_back_busy", busy, 1);
        pulse();
        chk("menu_back_kh11", key_highlight, 11);
        for (int i = 0; i < 8; i++) pulse();
        chk("menu_back_drain", key_highlight, 0);

        // reset coincident with frame_start while pending
        kb(4'd2);
        Reset = 1'b1; frame_start = 1'b1;
        tick();
        Reset = 1'b0; frame_start = 1'b0;
        chk("rstp_kh", key_highlight, 0);
        chk("rstp_busy", busy, 0);
        pulse();
        chk("rstp_never_shown", key_highlight, 0);

        // reset during show blanks on the next edge
        kb(4'd6);
        pulse();
        chk("rsts_kh6", key_highlight, 6);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("rsts_kh0", key_highlight, 0);
        chk("rsts_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
